// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default sizes for the RAM clear sequencer / two-port arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 3;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    typedef logic req_idx_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester handshake plus RAM-side bus. slave = arbiter view, master = requesters and RAM.
interface ram_arb_if #(
    parameter int ADDR_W = ram_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = ram_arb_pkg::DATA_W_DEF
);
    logic [1:0]             rq_req;
    logic [1:0]             rq_we;
    logic [1:0][ADDR_W-1:0] rq_addr;
    logic [1:0][DATA_W-1:0] rq_wdata;
    logic [1:0]             rq_gnt;
    logic [1:0]             rq_rvalid;
    logic [DATA_W-1:0]      rq_rdata;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_data;
    logic                   ram_wren;
    logic [DATA_W-1:0]      ram_q;

    modport slave (
        input  rq_req, rq_we, rq_addr, rq_wdata, ram_q,
        output rq_gnt, rq_rvalid, rq_rdata, ram_addr, ram_data, ram_wren
    );

    modport master (
        output rq_req, rq_we, rq_addr, rq_wdata, ram_q,
        input  rq_gnt, rq_rvalid, rq_rdata, ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin: prio picks the winner only when both request.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   prio,
    output logic [1:0] gnt,
    output req_idx_t   prio_nxt
);

    always_comb begin
        gnt      = req;
        prio_nxt = prio;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
        // The loser of this grant gets priority next time.
        if (gnt[0]) begin
            prio_nxt = 1'b1;
        end else if (gnt[1]) begin
            prio_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Clears the whole RAM after reset or on clr_start, then shares the RAM port
// between two requesters with round-robin arbitration.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clr_start,
    output logic     clr_busy,
    ram_arb_if.slave bus
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    req_idx_t          prio_q,    prio_d;
    logic [1:0]        rvalid_q,  rvalid_d;

    logic [1:0]        arb_req;
    logic [1:0]        gnt;
    req_idx_t          prio_nxt;
    req_idx_t          sel;
    logic              wren_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] data_c;

    // A clear request steals the cycle from both requesters.
    assign arb_req = (state_q == S_SERVE && !clr_start) ? bus.rq_req : 2'b00;

    rr_arb2 u_arb (
        .req      (arb_req),
        .prio     (prio_q),
        .gnt      (gnt),
        .prio_nxt (prio_nxt)
    );

    assign sel = gnt[1];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        prio_d    = prio_nxt;
        rvalid_d  = gnt & ~bus.rq_we;
        clr_busy  = 1'b0;
        wren_c    = 1'b0;
        addr_c    = '0;
        data_c    = '0;
        unique case (state_q)
            S_CLEAR: begin
                clr_busy  = 1'b1;
                wren_c    = 1'b1;
                addr_c    = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d   = S_SERVE;
                    clr_cnt_d = '0;
                end
            end
            S_SERVE: begin
                if (clr_start) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end else if (|gnt) begin
                    wren_c = bus.rq_we[sel];
                    addr_c = bus.rq_addr[sel];
                    data_c = bus.rq_wdata[sel];
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            prio_q    <= 1'b0;
            rvalid_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            prio_q    <= prio_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Write enable is gated so no stray write lands while reset is held.
    assign bus.ram_wren  = wren_c & reset;
    assign bus.ram_addr  = addr_c;
    assign bus.ram_data  = data_c;
    assign bus.rq_gnt    = gnt;
    assign bus.rq_rvalid = rvalid_q;
    assign bus.rq_rdata  = bus.ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32x3 registered-output RAM.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 3;
    localparam int DEPTH = 32;

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic clr_start = 1'b0;
    logic clr_busy;

    int n_chk  = 0;
    int n_pass = 0;

    ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.rq_req   = 2'b00;
        bus.rq_we    = 2'b00;
        bus.rq_addr  = '0;
        bus.rq_wdata = '0;
    endtask

    task automatic set_rq(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.rq_req[i]   = 1'b1;
        bus.rq_we[i]    = we;
        bus.rq_addr[i]  = a;
        bus.rq_wdata[i] = d;
    endtask

    // Called at the falling edge of the first clear cycle; returns at the first serve cycle.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk(tag, {clr_busy, bus.ram_wren, bus.rq_gnt, bus.ram_addr, bus.ram_data},
                {1'b1, 1'b1, 2'b00, 5'(i), 3'b000});
            @(negedge clk);
        end
        #1;
        chk({tag, "_done"}, {clr_busy, bus.ram_wren, bus.rq_gnt, bus.ram_addr, bus.ram_data},
            {1'b0, 1'b0, 2'b00, 5'd0, 3'b000});
    endtask

    task automatic check_reset_vals(input string tag);
        chk(tag, {clr_busy, bus.ram_wren, bus.rq_gnt, bus.rq_rvalid, bus.ram_addr, bus.ram_data},
            {1'b1, 1'b0, 2'b00, 2'b00, 5'd0, 3'b000});
    endtask

    initial begin
        idle();
        #12;
        check_reset_vals("reset_hold");
        @(negedge clk);
        #1;
        check_reset_vals("reset_hold_edge");

        @(negedge clk);
        reset = 1'b1;
        check_sweep("sweep1");

        // write then read back through requester 0
        set_rq(0, 1'b1, 5'd5, 3'b011);
        #1;
        chk("wr5", {bus.rq_gnt, bus.ram_wren, bus.ram_addr, bus.ram_data}, {2'b01, 1'b1, 5'd5, 3'b011});
        @(negedge clk);
        idle();
        set_rq(0, 1'b0, 5'd5, 3'b000);
        #1;
        chk("rd5", {bus.rq_gnt, bus.ram_wren, bus.ram_addr, bus.rq_rvalid}, {2'b01, 1'b0, 5'd5, 2'b00});
        @(negedge clk);
        idle();
        #1;
        chk("rd5_data", {bus.rq_rvalid, bus.rq_rdata}, {2'b01, 3'b011});

        // lone requester 1 read; prio returns to 0
        set_rq(1, 1'b0, 5'd0, 3'b000);
        #1;
        chk("rd0_r1", {bus.rq_gnt, bus.ram_addr}, {2'b10, 5'd0});
        @(negedge clk);
        idle();
        #1;
        chk("rd0_r1_data", {bus.rq_rvalid, bus.rq_rdata}, {2'b10, 3'b000});

        // contention for 6 cycles
        for (int k = 0; k < 6; k++) begin
            set_rq(0, 1'b0, 5'd7, 3'b000);
            set_rq(1, 1'b0, 5'd9, 3'b000);
            #1;
            chk("rr_gnt", {bus.rq_gnt, bus.ram_addr},
                (k % 2 == 0) ? {2'b01, 5'd7} : {2'b10, 5'd9});
            if (k > 0) chk("rr_rvalid", {30'd0, bus.rq_rvalid}, (k % 2 == 0) ? 32'd2 : 32'd1);
            @(negedge clk);
        end
        idle();
        #1;
        chk("serve_idle", {bus.rq_gnt, bus.ram_wren, bus.ram_addr, bus.ram_data, bus.rq_rvalid},
            {2'b00, 1'b0, 5'd0, 3'b000, 2'b10});

        // clr_start wins over a pending write from requester 1
        @(negedge clk);
        set_rq(1, 1'b1, 5'd5, 3'b110);
        clr_start = 1'b1;
        #1;
        chk("clr_start_nogrant", {bus.rq_gnt, bus.ram_wren, clr_busy}, {2'b00, 1'b0, 1'b0});
        @(negedge clk);
        clr_start = 1'b0;
        idle();
        check_sweep("sweep2");

        set_rq(0, 1'b0, 5'd5, 3'b000);
        #1;
        chk("rd5_after_clr", bus.rq_gnt, 2'b01);
        @(negedge clk);
        idle();
        #1;
        chk("rd5_after_clr_data", {bus.rq_rvalid, bus.rq_rdata}, {2'b01, 3'b000});

        // reset asserted at clear address 10; prio is 1 at this point
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("sweep_at10", {clr_busy, bus.ram_wren, bus.ram_addr}, {1'b1, 1'b1, 5'd10});
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals("reset_mid_sweep");
        @(negedge clk);
        #1;
        check_reset_vals("reset_mid_sweep_hold");
        @(negedge clk);
        reset = 1'b1;
        check_sweep("sweep3");

        // prio must be back at 0 after reset
        set_rq(0, 1'b0, 5'd1, 3'b000);
        set_rq(1, 1'b0, 5'd3, 3'b000);
        #1;
        chk("prio_after_reset", bus.rq_gnt, 2'b01);
        @(negedge clk);
        idle();

        // read-after-write across requesters
        set_rq(0, 1'b1, 5'd2, 3'b101);
        #1;
        chk("wr2_r0", {bus.rq_gnt, bus.ram_wren, bus.ram_addr, bus.ram_data}, {2'b01, 1'b1, 5'd2, 3'b101});
        @(negedge clk);
        idle();
        set_rq(1, 1'b0, 5'd2, 3'b000);
        #1;
        chk("rd2_r1", {bus.rq_gnt, bus.ram_wren, bus.ram_addr}, {2'b10, 1'b0, 5'd2});
        @(negedge clk);
        idle();
        #1;
        chk("rd2_r1_data", {bus.rq_rvalid, bus.rq_rdata}, {2'b10, 3'b101});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
